// File: rtl/fir_sym_stream_core.sv
// fir_sym_stream_core
//   Streaming symmetric/antisymmetric FIR with a run-time loadable,
//   double-buffered coefficient bank. The pipeline has three register stages:
//   delay line, pre-add/multiply and sum/round/saturate. Every stage advances
//   only while the output register can move (en = !m_valid || m_ready).
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   s_valid/s_ready     input handshake; s_ready is combinational (= en)
//   s_data              signed input sample, DATA_WL bits, DATA_FL fraction bits
//   mode                0: x[k]+x[T-1-k], 1: x[k]-x[T-1-k]; captured per sample
//   cfg_we/addr/data    write one shadow coefficient (addresses >= NC ignored)
//   cfg_commit          copy the shadow bank into the active bank
//   m_valid/m_ready     output handshake
//   m_data              signed result, OUT_WL bits, OUT_FL fraction bits
//   m_sat               m_data was clipped (qualified by m_valid)
module fir_sym_stream_core #(
    parameter int TAPS     = 10,
    parameter int DATA_WL  = 14,
    parameter int DATA_FL  = 6,
    parameter int COEFF_WL = 9,
    parameter int COEFF_FL = 7,
    parameter int OUT_WL   = 20,
    parameter int OUT_FL   = 12,
    parameter logic [(TAPS/2)*COEFF_WL-1:0] COEFF_INIT = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic signed [DATA_WL-1:0]         s_data,
    input  logic                              mode,
    input  logic                              cfg_we,
    input  logic        [$clog2(TAPS/2)-1:0]  cfg_addr,
    input  logic signed [COEFF_WL-1:0]        cfg_data,
    input  logic                              cfg_commit,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic signed [OUT_WL-1:0]          m_data,
    output logic                              m_sat
);

    localparam int NC     = TAPS / 2;
    localparam int AW     = $clog2(NC);
    localparam int PRE_W  = DATA_WL + 1;
    localparam int PROD_W = PRE_W + COEFF_WL;
    localparam int SUM_W  = PROD_W + $clog2(NC);
    localparam int D      = DATA_FL + COEFF_FL - OUT_FL;
    localparam int RSH    = (D > 0) ? D : 0;
    // One spare bit for the rounding add, and wide enough to hold the
    // output limits even when the sum is narrower than the output.
    localparam int ACC_W  = ((SUM_W + 1 > OUT_WL) ? SUM_W + 1 : OUT_WL) + 1;
    localparam logic signed [ACC_W-1:0] RND = ACC_W'((2 ** RSH) / 2);

    if (OUT_FL > DATA_FL + COEFF_FL) begin : g_bad_out_fl
        $error("OUT_FL must not exceed DATA_FL + COEFF_FL");
    end
    if ((TAPS % 2) != 0 || TAPS < 4) begin : g_bad_taps
        $error("TAPS must be even and at least 4");
    end

    function automatic logic signed [ACC_W-1:0] round_half_up(input logic signed [SUM_W-1:0] s);
        logic signed [ACC_W-1:0] t;
        t = ACC_W'(s) + RND;
        return t >>> RSH;
    endfunction

    // Returns {sat, data}.
    function automatic logic [OUT_WL:0] saturate(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = ACC_W'({1'b0, {(OUT_WL-1){1'b1}}});
        lo = ~hi;
        if (v > hi)      return {1'b1, 1'b0, {(OUT_WL-1){1'b1}}};
        else if (v < lo) return {1'b1, 1'b1, {(OUT_WL-1){1'b0}}};
        else             return {1'b0, v[OUT_WL-1:0]};
    endfunction

    logic                        en;
    logic signed [DATA_WL-1:0]   x_p0   [TAPS];
    logic                        mode_p0;
    logic                        vld_p0;
    logic signed [COEFF_WL-1:0]  c_shd  [NC];
    logic signed [COEFF_WL-1:0]  c_act  [NC];
    logic signed [PRE_W-1:0]     pre    [NC];
    logic signed [PROD_W-1:0]    prod   [NC];
    logic signed [PROD_W-1:0]    prod_p1[NC];
    logic                        vld_p1;
    logic signed [SUM_W-1:0]     sum;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;

    // Coefficient banks. Commit ignores en so it also lands during a stall;
    // a write in the commit cycle is forwarded straight into the active bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NC; k++) begin
                c_shd[k] <= COEFF_INIT[k*COEFF_WL +: COEFF_WL];
                c_act[k] <= COEFF_INIT[k*COEFF_WL +: COEFF_WL];
            end
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (cfg_we && cfg_addr == AW'(k))
                    c_shd[k] <= cfg_data;
                if (cfg_commit)
                    c_act[k] <= (cfg_we && cfg_addr == AW'(k)) ? cfg_data : c_shd[k];
            end
        end
    end

    // ---- stage 0: delay line accepts the sample ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) x_p0[k] <= '0;
            mode_p0 <= 1'b0;
            vld_p0  <= 1'b0;
        end else if (en) begin
            vld_p0 <= s_valid;
            if (s_valid) begin
                for (int k = TAPS - 1; k > 0; k--) x_p0[k] <= x_p0[k-1];
                x_p0[0] <= s_data;
                mode_p0 <= mode;
            end
        end
    end

    // ---- stage 1: pre-add and full-precision multiply ----
    always_comb begin
        for (int k = 0; k < NC; k++) begin
            pre[k]  = mode_p0 ? PRE_W'(x_p0[k]) - PRE_W'(x_p0[TAPS-1-k])
                              : PRE_W'(x_p0[k]) + PRE_W'(x_p0[TAPS-1-k]);
            prod[k] = PROD_W'(pre[k]) * PROD_W'(c_act[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NC; k++) prod_p1[k] <= '0;
            vld_p1 <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < NC; k++) prod_p1[k] <= prod[k];
            vld_p1 <= vld_p0;
        end
    end

    // ---- stage 2: sum, round half up, saturate ----
    always_comb begin
        sum = '0;
        for (int k = 0; k < NC; k++) sum = sum + SUM_W'(prod_p1[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sat   <= 1'b0;
        end else if (en) begin
            m_valid         <= vld_p1;
            {m_sat, m_data} <= saturate(round_half_up(sum));
        end
    end

endmodule

// File: tb/tb_fir_sym_stream_core.sv
module tb_fir_sym_stream_core;

    localparam logic [44:0] INIT = {9'd5, 9'd4, 9'd3, 9'd2, 9'd1};

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [13:0] s_data = '0;
    logic               mode = 1'b0;
    logic               cfg_we = 1'b0;
    logic        [2:0]  cfg_addr = '0;
    logic signed [8:0]  cfg_data = '0;
    logic               cfg_commit = 1'b0;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic signed [19:0] m_data;
    logic               m_sat;

    fir_sym_stream_core #(.COEFF_INIT(INIT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .mode(mode),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic signed [19:0] got_q[$];
    logic               sat_q[$];
    longint             exp_q[$];
    logic signed [13:0] mx[10];
    int                 mc[5] = '{1, 2, 3, 4, 5};
    bit                 bp_on = 0;
    bit                 stall_prev = 0;
    logic signed [19:0] hold_data = '0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Direct convolution over all ten taps with the mirrored coefficient set.
    function automatic longint model_y(input bit md);
        longint acc = 0;
        longint h;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) h = mc[i];
            else       h = md ? -mc[9-i] : mc[9-i];
            acc += h * longint'(mx[i]);
        end
        acc = (acc + 1) >>> 1;
        if (acc > 524287)  acc = 524287;
        if (acc < -524288) acc = -524288;
        return acc;
    endfunction

    always @(posedge clk) begin
        if (bp_on) begin
            #1;
            m_ready = ($urandom_range(0, 99) < 30);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bp_on) begin
                check_val("bp_ready", s_ready, !(m_valid && !m_ready));
                if (stall_prev) check_val("bp_hold", m_data, hold_data);
                stall_prev = m_valid && !m_ready;
                hold_data  = m_data;
                if (s_valid && s_ready) begin
                    for (int i = 9; i > 0; i--) mx[i] = mx[i-1];
                    mx[0] = s_data;
                    exp_q.push_back(model_y(mode));
                end
            end
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                sat_q.push_back(m_sat);
                if (bp_on) begin
                    if (exp_q.size() == 0) check_val("bp_extra", 1, 0);
                    else                   check_val("bp_data", m_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic push_sample(input int d, input bit md);
        bit acc = 0;
        int cnt = 0;
        s_valid = 1'b1;
        s_data  = 14'(d);
        mode    = md;
        while (!acc && cnt < 500) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            cnt++;
        end
        s_valid = 1'b0;
        if (!acc) check_val("push_timeout", 0, 1);
    endtask

    task automatic wait_outputs(input int n);
        int cnt = 0;
        while (got_q.size() < n && cnt < 300) begin
            step(1);
            cnt++;
        end
        if (got_q.size() < n) check_val("out_timeout", got_q.size(), n);
    endtask

    task automatic cfg_write(input int a, input int d, input bit c);
        cfg_we     = 1'b1;
        cfg_addr   = 3'(a);
        cfg_data   = 9'(d);
        cfg_commit = c;
        step(1);
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    int imp_sym[10]  = '{32, 64, 96, 128, 160, 160, 128, 96, 64, 32};
    int imp_anti[10] = '{32, 64, 96, 128, 160, -160, -128, -96, -64, -32};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        #2;
        do_reset();
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_m_data", m_data, 0);
        check_val("rst_m_sat", m_sat, 0);
        check_val("rst_s_ready", s_ready, 1);

        // symmetric impulse with the reset coefficients {1,2,3,4,5}
        got_q.delete(); sat_q.delete();
        push_sample(64, 0);
        for (int i = 0; i < 9; i++) push_sample(0, 0);
        wait_outputs(10);
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            check_val($sformatf("imp_sym[%0d]", i), got_q[i], imp_sym[i]);
        if (sat_q.size() > 4) check_val("imp_sym_sat", sat_q[4], 0);

        // antisymmetric impulse
        do_reset();
        got_q.delete(); sat_q.delete();
        push_sample(64, 1);
        for (int i = 0; i < 9; i++) push_sample(0, 1);
        wait_outputs(10);
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            check_val($sformatf("imp_anti[%0d]", i), got_q[i], imp_anti[i]);

        // rounding and latency: c = {1,0,0,0,0}
        do_reset();
        cfg_write(0, 1, 0);
        cfg_write(1, 0, 0);
        cfg_write(2, 0, 0);
        cfg_write(3, 0, 0);
        cfg_write(4, 0, 1);
        got_q.delete(); sat_q.delete();
        push_sample(1, 0);
        check_val("lat_edge1_vld", m_valid, 0);
        step(1);
        check_val("lat_edge2_vld", m_valid, 0);
        step(1);
        check_val("lat_edge3_vld", m_valid, 1);
        check_val("round_pos", m_data, 1);
        push_sample(-1, 0);
        wait_outputs(2);
        if (got_q.size() > 1) check_val("round_neg", got_q[1], 0);

        // saturation with all c = 0x0FF
        do_reset();
        for (int k = 0; k < 5; k++) cfg_write(k, 255, k == 4);
        got_q.delete(); sat_q.delete();
        for (int i = 0; i < 10; i++) push_sample(8191, 0);
        wait_outputs(10);
        if (got_q.size() > 9) begin
            check_val("sat_pos_data", got_q[9], 524287);
            check_val("sat_pos_flag", sat_q[9], 1);
        end
        got_q.delete(); sat_q.delete();
        for (int i = 0; i < 10; i++) push_sample(-8192, 0);
        wait_outputs(10);
        if (got_q.size() > 9) begin
            check_val("sat_neg_data", got_q[9], -524288);
            check_val("sat_neg_flag", sat_q[9], 1);
        end

        // shadow writes, commit mid-stream, forwarded commit
        do_reset();
        for (int k = 0; k < 5; k++) cfg_write(k, 2, 0);
        got_q.delete(); sat_q.delete();
        for (int i = 0; i < 10; i++) push_sample(64, 0);
        push_sample(64, 0);
        cfg_commit = 1'b1;
        push_sample(64, 0);
        cfg_commit = 1'b0;
        push_sample(64, 0);
        wait_outputs(13);
        if (got_q.size() > 12) begin
            check_val("shadow_only", got_q[9], 960);
            check_val("commit_edge_old", got_q[10], 960);
            check_val("commit_after_new", got_q[11], 640);
            check_val("commit_next_new", got_q[12], 640);
        end
        cfg_write(0, 0, 1);
        push_sample(64, 0);
        wait_outputs(14);
        if (got_q.size() > 13) check_val("commit_forward", got_q[13], 512);

        // reset mid-stream while m_valid is high
        push_sample(64, 0);
        push_sample(64, 0);
        push_sample(64, 0);
        check_val("pre_rst_vld", m_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_mid_vld", m_valid, 0);
        check_val("rst_mid_ready", s_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete(); sat_q.delete();
        push_sample(64, 0);
        for (int i = 0; i < 4; i++) push_sample(0, 0);
        wait_outputs(5);
        if (got_q.size() > 4) begin
            check_val("post_rst_c0", got_q[0], 32);
            check_val("post_rst_c4", got_q[4], 160);
        end

        // random backpressure against the model, reset coefficients
        do_reset();
        for (int i = 0; i < 10; i++) mx[i] = '0;
        exp_q.delete();
        stall_prev = 0;
        bp_on = 1;
        for (int i = 0; i < 60; i++)
            push_sample(int'($urandom_range(0, 16383)) - 8192, 1'($urandom_range(0, 1)));
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 1000) begin
            step(1);
            cnt++;
        end
        if (exp_q.size() != 0) check_val("bp_drain", exp_q.size(), 0);
        bp_on = 0;
        step(2);
        m_ready = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
